mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg: shared state encoding and default widths for mem_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LINE_WIDTH = 256;
  localparam int DEF_TIMEOUT    = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter: round-robin arbiter of icache/dcache line requests onto one
//              memory port, with a sticky acknowledge-timeout flag.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] iad,
  input  logic                  imreq,
  output logic                  acki_n,
  input  logic [ADDR_WIDTH-1:0] dad,
  input  logic                  dmreq,
  input  logic                  dmwrite,
  input  logic [LINE_WIDTH-1:0] dwdata,
  output logic                  ackd_n,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic                  mreq,
  output logic                  mwrite,
  output logic [LINE_WIDTH-1:0] mwdata,
  input  logic [LINE_WIDTH-1:0] mrdata,
  input  logic                  ackm_n,
  output logic                  err
);

  localparam int               C_CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT);

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_last_d;
  logic                 r_err;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic                 r_mwrite;
  logic [LINE_WIDTH-1:0] r_mwdata;
  logic                 w_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    mreq      = 1'b0;
    acki_n    = 1'b1;
    ackd_n    = 1'b1;
    case (r_state)
      IDLE: begin
        // on a tie, grant the requester that was not granted last
        if (dmreq && (!imreq || !r_last_d)) w_next = GNT_D;
        else if (imreq)                     w_next = GNT_I;
      end
      GNT_I, GNT_D: begin
        mreq      = 1'b1;
        w_timeout = ackm_n && (r_cnt == C_TIMEOUT);
        if (!ackm_n || w_timeout) w_next = IDLE;
        if (!ackm_n && !rst) begin
          if (r_state == GNT_I) acki_n = 1'b0;
          else                  ackd_n = 1'b0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_last_d <= 1'b0;
      r_err    <= 1'b0;
      r_maddr  <= '0;
      r_mwrite <= 1'b0;
      r_mwdata <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (w_next == GNT_D) begin
          r_maddr  <= dad;
          r_mwrite <= dmwrite;
          r_mwdata <= dwdata;
          r_last_d <= 1'b1;
        end else if (w_next == GNT_I) begin
          r_maddr  <= iad;
          r_mwrite <= 1'b0;
          r_mwdata <= '0;
          r_last_d <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign maddr  = r_maddr;
  assign mwrite = r_mwrite;
  assign mwdata = r_mwdata;
  assign err    = r_err;
  assign rdata  = mrdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
//                 transaction-level model of grants, acks and timeouts.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 64;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] iad = '0;
  logic          imreq = 1'b0;
  logic          acki_n;
  logic [AW-1:0] dad = '0;
  logic          dmreq = 1'b0;
  logic          dmwrite = 1'b0;
  logic [LW-1:0] dwdata = '0;
  logic          ackd_n;
  logic [LW-1:0] rdata;
  logic [AW-1:0] maddr;
  logic          mreq;
  logic          mwrite;
  logic [LW-1:0] mwdata;
  logic [LW-1:0] mrdata = '0;
  logic          ackm_n = 1'b1;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .iad(iad), .imreq(imreq), .acki_n(acki_n),
    .dad(dad), .dmreq(dmreq), .dmwrite(dmwrite), .dwdata(dwdata), .ackd_n(ackd_n),
    .rdata(rdata),
    .maddr(maddr), .mreq(mreq), .mwrite(mwrite), .mwdata(mwdata),
    .mrdata(mrdata), .ackm_n(ackm_n), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: owner 0 = nobody, 1 = icache, 2 = dcache.
  int            m_owner  = 0;
  int            m_age    = 0;
  bit            m_last_d = 1'b0;
  bit            m_err    = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  bit            m_write  = 1'b0;
  logic [LW-1:0] m_data   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_age = 0; m_last_d = 1'b0; m_err = 1'b0;
    end else if (m_owner == 0) begin
      if (imreq && dmreq) m_owner = m_last_d ? 1 : 2;
      else if (dmreq)     m_owner = 2;
      else if (imreq)     m_owner = 1;
      m_age = 0;
      if (m_owner == 2) begin
        m_addr = dad; m_write = dmwrite; m_data = dwdata; m_last_d = 1'b1;
      end else if (m_owner == 1) begin
        m_addr = iad; m_write = 1'b0; m_last_d = 1'b0;
      end
    end else begin
      m_age++;
      if (!ackm_n)            m_owner = 0;
      else if (m_age > TMO) begin m_err = 1'b1; m_owner = 0; end
    end
  end

  always @(negedge clk) begin
    chk("mreq",   64'(mreq),   64'(m_owner != 0));
    chk("acki_n", 64'(acki_n), 64'(!(m_owner == 1 && !ackm_n && !rst)));
    chk("ackd_n", 64'(ackd_n), 64'(!(m_owner == 2 && !ackm_n && !rst)));
    chk("err",    64'(err),    64'(m_err));
    chk("rdata",  64'(rdata),  64'(mrdata));
    if (m_owner != 0) begin
      chk("maddr",  64'(maddr),  64'(m_addr));
      chk("mwrite", 64'(mwrite), 64'(m_write));
      if (m_owner == 2) chk("mwdata", 64'(mwdata), 64'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imreq = 1'b0; dmreq = 1'b0; dmwrite = 1'b0; ackm_n = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and single icache read with ack at cycle 5
    do_reset();
    #1;
    chk("rst_mreq", 64'(mreq), 64'd0);
    chk("rst_maddr", 64'(maddr), 64'd0);
    chk("rst_mwrite", 64'(mwrite), 64'd0);
    chk("rst_mwdata", 64'(mwdata), 64'd0);
    chk("rst_acks", 64'({acki_n, ackd_n}), 64'd3);
    chk("rst_err", 64'(err), 64'd0);
    imreq = 1'b1; iad = 32'h100;
    step(); #1;
    chk("i_mreq_c1", 64'(mreq), 64'd1);
    chk("i_maddr_c1", 64'(maddr), 64'h100);
    chk("i_mwrite_c1", 64'(mwrite), 64'd0);
    imreq = 1'b0;
    repeat (3) step();
    #1 chk("i_mreq_c4", 64'(mreq), 64'd1);
    step(); ackm_n = 1'b0;
    #1 chk("i_acks_c5", 64'({acki_n, ackd_n}), 64'b01);
    step(); ackm_n = 1'b1;
    #1 chk("i_mreq_c6", 64'(mreq), 64'd0);
    chk("i_acki_c6", 64'(acki_n), 64'd1);

    // Round-robin ties: D, then I, then D
    do_reset();
    imreq = 1'b1; dmreq = 1'b1; iad = 32'h40; dad = 32'h80;
    step(); #1 chk("tie1_d", 64'(maddr), 64'h80);
    step(); ackm_n = 1'b0;
    #1 chk("tie1_ack", 64'({acki_n, ackd_n}), 64'b10);
    step(); ackm_n = 1'b1;
    #1 chk("tie1_idle", 64'(mreq), 64'd0);
    step(); #1 chk("tie2_i", 64'(maddr), 64'h40);
    step(); ackm_n = 1'b0;
    #1 chk("tie2_ack", 64'({acki_n, ackd_n}), 64'b01);
    step(); ackm_n = 1'b1;
    #1 chk("tie2_idle", 64'(mreq), 64'd0);
    step(); #1 chk("tie3_d", 64'(maddr), 64'h80);
    step(); ackm_n = 1'b0; imreq = 1'b0; dmreq = 1'b0;
    #1 chk("tie3_ack", 64'({acki_n, ackd_n}), 64'b10);
    step(); ackm_n = 1'b1;

    // Dcache write, data held while dwdata changes
    dmreq = 1'b1; dmwrite = 1'b1; dad = 32'h2000; dwdata = {8{8'hA5}};
    step(); #1;
    chk("w_mwrite", 64'(mwrite), 64'd1);
    chk("w_maddr", 64'(maddr), 64'h2000);
    chk("w_mwdata", 64'(mwdata), {8{8'hA5}});
    dwdata = {8{8'h5A}}; dmreq = 1'b0; dmwrite = 1'b0;
    step(); #1 chk("w_mwdata_hold", 64'(mwdata), {8{8'hA5}});
    step(); ackm_n = 1'b0;
    step(); ackm_n = 1'b1;

    // Timeout after TMO+1 grant cycles without ack
    imreq = 1'b1; iad = 32'h300;
    step(); imreq = 1'b0;
    for (int k = 1; k <= TMO + 1; k++) begin
      #1 chk("to_busy", 64'({mreq, err}), 64'b10);
      step();
    end
    #1 chk("to_end", 64'({mreq, err, acki_n, ackd_n}), 64'b0111);
    step(); #1 chk("to_sticky", 64'(err), 64'd1);

    // Reset in the middle of a dcache grant
    dmreq = 1'b1; dad = 32'h500;
    step(); #1 chk("rg_mreq", 64'(mreq), 64'd1);
    dmreq = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    #1 chk("rg_after", 64'({mreq, err}), 64'b00);
    ackm_n = 1'b0;
    #1 chk("rg_noack", 64'({acki_n, ackd_n}), 64'b11);
    step(); #1 chk("idle_ack_nostate", 64'(mreq), 64'd0);
    ackm_n = 1'b1;

    // Randomized traffic; some epochs never ack so grants time out
    for (int ep = 0; ep < 10; ep++) begin
      int ack_pct;
      ack_pct = (ep % 3 == 0) ? 0 : 15 + 10 * (ep % 4);
      for (int c = 0; c < 300; c++) begin
        step();
        imreq   = ($urandom_range(99) < 40);
        dmreq   = ($urandom_range(99) < 40);
        dmwrite = $urandom_range(1);
        iad     = $urandom;
        dad     = $urandom;
        dwdata  = {$urandom, $urandom};
        mrdata  = {$urandom, $urandom};
        ackm_n  = !($urandom_range(99) < ack_pct);
        rst     = ($urandom_range(399) == 0);
      end
    end
    step(); rst = 1'b0; imreq = 1'b0; dmreq = 1'b0; ackm_n = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
